queue_ring: RTL and testbench
=============================

Name: queue_ring

Overview:
- Parametrised circular-buffer queue: successor to the fixed 8x8 shift-register queue, on the clock_10KHZ domain.
- Uses read/write pointers, so nothing shifts on dequeue.
- Accepts level-style enqueue/dequeue requests from slow control logic and executes exactly one operation per request assertion.
- Adds simultaneous enqueue+dequeue, full/empty flags, sticky overflow/underflow errors and a one-cycle data_valid strobe.

Parameters:
- DATA_W, 8, width of each entry.
- DEPTH, 8, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; never overridden).
- LEN_W, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- clock_10KHZ  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- data_in  in  DATA_W  entry written on enqueue.
- enqueue_in  in  1  enqueue request (level); acted on once per assertion.
- dequeue_in  in  1  dequeue request (level); acted on once per assertion.
- clear_err  in  1  synchronous clear of overflow/underflow.
- data_out  out  DATA_W  last dequeued entry; held until next successful dequeue.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- len_out  out  LEN_W  current occupancy, 0..DEPTH.
- full  out  1  len_out == DEPTH.
- empty  out  1  len_out == 0.
- overflow  out  1  sticky: enqueue attempted while full (and not simultaneous with a dequeue).
- underflow  out  1  sticky: dequeue attempted while empty.
- EA_queue  out  2  current FSM state, for debug.

Behaviour:
- Reset (async, any time, including mid-operation):
  - len_out=0, rd/wr pointers=0, data_out=0, data_valid=0, overflow=0, underflow=0, EA_queue=IDLE.
  - empty=1, full=0.
  - Any latched request is discarded. Storage contents are not cleared and are don't-care.
- FSM encoding: IDLE=2'b00, EXEC=2'b01, HOLD=2'b10. 2'b11 is unused and recovers to IDLE.
- IDLE:
  - If enqueue_in or dequeue_in is high at a rising edge: latch enq_req/deq_req from the current inputs and data_in into a holding register, then go to EXEC.
  - Otherwise stay in IDLE.
- EXEC (exactly one cycle): perform the latched operation(s) at the next edge.
  - Then go to HOLD if either request input is still high, else IDLE.
- HOLD:
  - Stay while enqueue_in or dequeue_in is high; go to IDLE when both are low.
  - New assertions during HOLD are ignored: one operation per request pulse, regardless of pulse length.
- Latency: request sampled at edge N; memory, len_out and data_out update at edge N+1. data_valid is high for the cycle after edge N+1 only.
- Enqueue only:
  - Not full: mem[wr_ptr]<=held data; wr_ptr+1 modulo DEPTH; len_out+1.
  - Full: no state change; overflow<=1.
- Dequeue only:
  - Not empty: data_out<=mem[rd_ptr]; rd_ptr+1 modulo DEPTH; len_out-1; data_valid pulse.
  - Empty: data_out held; no data_valid; underflow<=1.
- Both latched together:
  - Not empty: dequeue head and enqueue new entry in the same edge; len_out unchanged; data_valid pulses. Valid when full, with no overflow.
  - Empty: enqueue performed (len_out 0->1); dequeue rejected; underflow<=1. No bypass of data_in to data_out.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 naturally. full/empty come from len_out, not from pointer compare.
- clear_err:
  - When high at an edge, overflow and underflow clear.
  - If an error event occurs in the same edge, the set wins.
- data_out is never cleared except by reset.

Test Plan:
- Reset, then idle 5 cycles -> len_out=0, empty=1, full=0, data_out=0, data_valid=0, EA_queue=2'b00.
- Enqueue 0x11..0x18 with DEPTH=8, each request held 3 cycles -> one write per pulse; len_out 1..8; full=1 after the 8th. A 9th enqueue (0x99) -> overflow=1, len_out=8, contents unchanged.
- Dequeue 8 times -> data_out sequence 0x11..0x18, one data_valid pulse each, empty=1 at end. A 9th dequeue -> underflow=1, data_out stays 0x18. clear_err pulse -> both errors 0.
- Wrap check: enqueue 5, dequeue 5, enqueue 8 (0xA0..0xA7), dequeue 8 -> data_out 0xA0..0xA7 in order.
- Simultaneous enqueue+dequeue:
  - Full queue, data_in=0xEE -> head out on data_out, len_out stays 8, no overflow; 0xEE emerges last.
  - Empty queue -> len_out=1, underflow=1.
- Assert reset during EXEC (one cycle after enqueue rise) -> len_out=0, EA_queue=IDLE immediately. After release, the still-high enqueue_in is treated as a new request.

Source files
------------

// File: rtl/queue_ring.sv
// Parametrised circular-buffer queue with level-style request handshake:
// one enqueue/dequeue operation per request assertion, sticky error flags.
module queue_ring #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock_10KHZ,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    input  logic              clear_err,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [LEN_W-1:0]  len_out,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow,
    output logic [1:0]        EA_queue
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_t;

    typedef struct packed {
        logic              enq;
        logic              deq;
        logic [DATA_W-1:0] data;
    } req_t;

    state_t                        state, state_nxt;
    req_t                          req;
    logic                          latch;
    logic [DEPTH-1:0][DATA_W-1:0]  mem;
    logic [PTR_W-1:0]              wr_ptr, rd_ptr;
    logic                          exec, enq_ok, deq_ok, set_ovf, set_udf;

    assign full     = (len_out == LEN_W'(DEPTH));
    assign empty    = (len_out == '0);
    assign EA_queue = state;

    // A dequeue frees the head slot first, so enqueue into a full queue
    // succeeds when paired with a dequeue.
    assign exec    = (state == EXEC);
    assign deq_ok  = exec && req.deq && !empty;
    assign enq_ok  = exec && req.enq && (!full || deq_ok);
    assign set_ovf = exec && req.enq && !enq_ok;
    assign set_udf = exec && req.deq && empty;

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            IDLE: if (enqueue_in || dequeue_in) begin
                state_nxt = EXEC;
                latch     = 1'b1;
            end
            EXEC: state_nxt = (enqueue_in || dequeue_in) ? HOLD : IDLE;
            HOLD: if (!enqueue_in && !dequeue_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_10KHZ or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            len_out    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_valid <= deq_ok;
            if (latch) req <= '{enq: enqueue_in, deq: dequeue_in, data: data_in};
            if (enq_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq_ok) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                data_out <= mem[rd_ptr];
            end
            len_out   <= len_out + LEN_W'(enq_ok) - LEN_W'(deq_ok);
            // set beats clear when both land on the same edge
            overflow  <= (overflow  && !clear_err) || set_ovf;
            underflow <= (underflow && !clear_err) || set_udf;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clock_10KHZ) begin
        if (enq_ok) mem[wr_ptr] <= req.data;
    end
endmodule

// File: tb/tb_queue_ring.sv
// Randomised + directed bench for queue_ring against a queue-based
// behavioural model, checked on every falling edge.
module tb_queue_ring;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int LEN_W  = $clog2(DEPTH + 1);

    logic              clock_10KHZ = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic              enqueue_in = 1'b0, dequeue_in = 1'b0, clear_err = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid, full, empty, overflow, underflow;
    logic [LEN_W-1:0]  len_out;
    logic [1:0]        EA_queue;

    queue_ring #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock_10KHZ(clock_10KHZ), .reset(reset), .data_in(data_in),
        .enqueue_in(enqueue_in), .dequeue_in(dequeue_in), .clear_err(clear_err),
        .data_out(data_out), .data_valid(data_valid), .len_out(len_out),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
        .EA_queue(EA_queue)
    );

    always #50 clock_10KHZ = ~clock_10KHZ;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain queue plus request acceptance bookkeeping.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_dout, p_data;
    logic              m_dv, m_ovf, m_udf, pend, busy, p_enq, p_deq;

    always @(posedge clock_10KHZ or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_dout = '0; m_dv = 0; m_ovf = 0; m_udf = 0;
            pend = 0; busy = 0; p_enq = 0; p_deq = 0; p_data = '0;
        end else begin
            logic so, su;
            so = 0; su = 0; m_dv = 0;
            if (pend) begin
                if (p_deq) begin
                    if (mq.size() > 0) begin m_dout = mq.pop_front(); m_dv = 1; end
                    else su = 1;
                end
                if (p_enq) begin
                    if (mq.size() < DEPTH) mq.push_back(p_data);
                    else so = 1;
                end
            end
            m_ovf = (m_ovf && !clear_err) || so;
            m_udf = (m_udf && !clear_err) || su;
            if (pend) begin
                pend = 0;
                busy = enqueue_in || dequeue_in;
            end else if (busy) begin
                busy = enqueue_in || dequeue_in;
            end else if (enqueue_in || dequeue_in) begin
                pend = 1; p_enq = enqueue_in; p_deq = dequeue_in; p_data = data_in;
            end
        end
    end

    logic [DATA_W-1:0] seen[$];

    always @(negedge clock_10KHZ) begin
        check("data_out",   data_out,   m_dout);
        check("data_valid", data_valid, m_dv);
        check("len_out",    len_out,    mq.size());
        check("full",       full,       mq.size() == DEPTH);
        check("empty",      empty,      mq.size() == 0);
        check("overflow",   overflow,   m_ovf);
        check("underflow",  underflow,  m_udf);
        check("EA_queue",   EA_queue,   pend ? 1 : (busy ? 2 : 0));
        if (data_valid) seen.push_back(data_out);
    end

    task automatic req(input logic e, input logic d, input logic [DATA_W-1:0] v, input int hold);
        @(posedge clock_10KHZ); #2;
        enqueue_in = e; dequeue_in = d; data_in = v;
        repeat (hold) @(posedge clock_10KHZ);
        #2 enqueue_in = 0; dequeue_in = 0;
        repeat (2) @(posedge clock_10KHZ);
        #2;
    endtask

    task automatic pulse_clear();
        @(posedge clock_10KHZ); #2 clear_err = 1;
        @(posedge clock_10KHZ); #2 clear_err = 0;
    endtask

    task automatic check_seen(input string name, input logic [DATA_W-1:0] base, input int n);
        check({name, "_count"}, seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++)
            check(name, seen[i], base + DATA_W'(i));
    endtask

    initial begin
        int pe, pd;
        repeat (3) @(posedge clock_10KHZ);
        #2 reset = 0;
        repeat (5) @(posedge clock_10KHZ);
        #2;
        check("rst_len", len_out, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_dout", data_out, 0);
        check("rst_state", EA_queue, 0);

        for (int i = 0; i < 8; i++) req(1, 0, 8'h11 + 8'(i), 3);
        check("fill_len", len_out, 8);
        check("fill_full", full, 1);
        req(1, 0, 8'h99, 3);
        check("ovf_set", overflow, 1);
        check("ovf_len", len_out, 8);

        seen.delete();
        for (int i = 0; i < 8; i++) req(0, 1, 8'h00, 3);
        check_seen("drain", 8'h11, 8);
        check("drain_empty", empty, 1);
        req(0, 1, 8'h00, 3);
        check("udf_set", underflow, 1);
        check("udf_dout", data_out, 8'h18);
        pulse_clear();
        check("clr_ovf", overflow, 0);
        check("clr_udf", underflow, 0);

        for (int i = 0; i < 5; i++) req(1, 0, 8'h50 + 8'(i), 1);
        for (int i = 0; i < 5; i++) req(0, 1, 8'h00, 2);
        for (int i = 0; i < 8; i++) req(1, 0, 8'hA0 + 8'(i), 2);
        seen.delete();
        for (int i = 0; i < 8; i++) req(0, 1, 8'h00, 1);
        check_seen("wrap", 8'hA0, 8);

        for (int i = 0; i < 8; i++) req(1, 0, 8'h30 + 8'(i), 1);
        req(1, 1, 8'hEE, 2);
        check("both_full_len", len_out, 8);
        check("both_full_ovf", overflow, 0);
        check("both_full_dout", data_out, 8'h30);
        seen.delete();
        for (int i = 0; i < 8; i++) req(0, 1, 8'h00, 1);
        check("both_full_last", seen.size() == 8 ? seen[7] : 0, 8'hEE);

        req(1, 1, 8'h77, 2);
        check("both_empty_len", len_out, 1);
        check("both_empty_udf", underflow, 1);
        pulse_clear();

        @(posedge clock_10KHZ); #2 enqueue_in = 1; data_in = 8'h55;
        @(posedge clock_10KHZ); #10 reset = 1;
        #1;
        check("rst_exec_len", len_out, 0);
        check("rst_exec_state", EA_queue, 0);
        @(negedge clock_10KHZ); #5 reset = 0;
        repeat (2) @(posedge clock_10KHZ);
        #2;
        check("rearm_len", len_out, 1);
        check("rearm_state", EA_queue, 2);
        enqueue_in = 0;
        repeat (2) @(posedge clock_10KHZ);

        // random phases: fill-biased, drain-biased, balanced
        for (int ph = 0; ph < 3; ph++) begin
            pe = (ph == 0) ? 70 : (ph == 1) ? 20 : 50;
            pd = (ph == 0) ? 20 : (ph == 1) ? 70 : 50;
            repeat (250) begin
                @(posedge clock_10KHZ); #2;
                enqueue_in = ($urandom_range(0, 99) < pe);
                dequeue_in = ($urandom_range(0, 99) < pd);
                data_in    = DATA_W'($urandom);
                clear_err  = ($urandom_range(0, 19) == 0);
            end
        end
        #2 enqueue_in = 0; dequeue_in = 0; clear_err = 0;
        repeat (4) @(posedge clock_10KHZ);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
